// File: rtl/svo_vram_arb.sv
// Single-port VRAM arbiter: video reads take priority over CPU reads/writes, one grant per cycle.
// Define SVO_VRAM_ARB_STARVE_EN to force a CPU grant after MAX_VID_BURST back-to-back video grants.
module svo_vram_arb #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 24,
  parameter int MAX_VID_BURST = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {TAG_NONE, TAG_VID, TAG_CPU} tag_t;

  tag_t              tag_s1;
  tag_t              tag_s2;
  logic [DATA_W-1:0] vid_hold;
  logic [DATA_W-1:0] cpu_hold;
  logic              starve;

`ifdef SVO_VRAM_ARB_STARVE_EN
  localparam int CNT_W = $clog2(MAX_VID_BURST + 1);
  logic [CNT_W-1:0] starve_cnt;

  assign starve = (starve_cnt == CNT_W'(MAX_VID_BURST));

  // Counts video grants that the waiting CPU has lost since its last grant.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (cpu_ack || !cpu_req) begin
      starve_cnt <= '0;
    end else if (vid_ack) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  // Strict video priority; the burst limit only matters with the guard compiled in.
  assign starve = (MAX_VID_BURST < 0);
`endif

  always_comb begin
    vid_ack = 1'b0;
    cpu_ack = 1'b0;
    if (resetn) begin
      if (cpu_req && (!vid_req || starve)) begin
        cpu_ack = 1'b1;
      end else if (vid_req) begin
        vid_ack = 1'b1;
      end
    end
  end

  // tag_s1 follows the memory access cycle, tag_s2 the cycle its read data returns.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      tag_s1    <= TAG_NONE;
      tag_s2    <= TAG_NONE;
      vid_hold  <= '0;
      cpu_hold  <= '0;
    end else begin
      mem_en <= vid_ack | cpu_ack;
      mem_we <= cpu_ack & cpu_we;
      if (vid_ack) begin
        mem_addr <= vid_addr;
      end
      if (cpu_ack) begin
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
      end
      if (vid_ack) begin
        tag_s1 <= TAG_VID;
      end else if (cpu_ack && !cpu_we) begin
        tag_s1 <= TAG_CPU;
      end else begin
        tag_s1 <= TAG_NONE;
      end
      tag_s2 <= tag_s1;
      if (tag_s2 == TAG_VID) begin
        vid_hold <= mem_rdata;
      end
      if (tag_s2 == TAG_CPU) begin
        cpu_hold <= mem_rdata;
      end
    end
  end

  assign vid_rvalid = (tag_s2 == TAG_VID);
  assign cpu_rvalid = (tag_s2 == TAG_CPU);
  assign vid_rdata  = vid_rvalid ? mem_rdata : vid_hold;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_hold;

endmodule

// File: tb/tb_svo_vram_arb.sv
// Randomized bench for svo_vram_arb against a cycle-level transaction model and a behavioural VRAM.
module tb_svo_vram_arb;

  localparam int AW  = 16;
  localparam int DW  = 24;
  localparam int MAX = 8;
`ifdef SVO_VRAM_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_ack;
  logic          vid_rvalid;
  logic [DW-1:0] vid_rdata;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  svo_vram_arb #(.ADDR_W(AW), .DATA_W(DW), .MAX_VID_BURST(MAX)) dut (
    .clk(clk), .resetn(resetn),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return {a[7:0] ^ 8'hA5, a};
  endfunction

  // Behavioural VRAM driven by the DUT's memory port.
  logic [DW-1:0] env_mem [logic [AW-1:0]];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) env_mem[mem_addr] = mem_wdata;
      else mem_rdata <= env_mem.exists(mem_addr) ? env_mem[mem_addr] : dflt(mem_addr);
    end
  end

  // Reference model state: what the memory holds, and transactions in flight.
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  typedef struct packed {
    logic          en;
    logic          we;
    logic          own_vid;
    logic          own_cpu;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdat;
  } op_t;
  op_t           p1, p2;
  int            streak;
  logic [DW-1:0] exp_vrd, exp_crd;
  bit            rst_prev;

  int n_checks = 0;
  int n_fail   = 0;
  int obs_cpu_acks = 0;
  int obs_rvalids  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: compare DUT against the model mid-cycle, then advance the model.
  task automatic step(output bit va, output bit ca);
    bit  ev, ec, ovr;
    op_t g;
    @(negedge clk);
    ovr = STARVE_ON && (streak >= MAX);
    ev = 1'b0;
    ec = 1'b0;
    if (resetn) begin
      if (cpu_req && (!vid_req || ovr)) ec = 1'b1;
      else if (vid_req) ev = 1'b1;
    end
    check("vid_ack", {31'b0, vid_ack}, {31'b0, ev});
    check("cpu_ack", {31'b0, cpu_ack}, {31'b0, ec});
    check("mem_en", {31'b0, mem_en}, {31'b0, p1.en});
    check("mem_we", {31'b0, mem_we}, {31'b0, p1.we});
    if (p1.en || rst_prev) check("mem_addr", {16'b0, mem_addr}, {16'b0, p1.addr});
    if (p1.we || rst_prev) check("mem_wdata", {8'b0, mem_wdata}, {8'b0, p1.wdata});
    check("vid_rvalid", {31'b0, vid_rvalid}, {31'b0, p2.own_vid});
    check("cpu_rvalid", {31'b0, cpu_rvalid}, {31'b0, p2.own_cpu});
    if (p2.own_vid) exp_vrd = p2.rdat;
    if (p2.own_cpu) exp_crd = p2.rdat;
    check("vid_rdata", {8'b0, vid_rdata}, {8'b0, exp_vrd});
    check("cpu_rdata", {8'b0, cpu_rdata}, {8'b0, exp_crd});
    obs_cpu_acks += int'(cpu_ack === 1'b1);
    obs_rvalids  += int'(vid_rvalid === 1'b1) + int'(cpu_rvalid === 1'b1);

    if (!resetn) begin
      p1 = '0; p2 = '0; streak = 0; exp_vrd = '0; exp_crd = '0; rst_prev = 1'b1;
    end else begin
      rst_prev = 1'b0;
      p2 = p1;
      g = '0;
      if (ev || ec) begin
        g.en      = 1'b1;
        g.addr    = ev ? vid_addr : cpu_addr;
        g.we      = ec && cpu_we;
        g.own_vid = ev;
        g.own_cpu = ec && !cpu_we;
        if (g.we) begin
          g.wdata = cpu_wdata;
          ref_mem[cpu_addr] = cpu_wdata;
        end else begin
          g.wdata = p1.wdata;
          g.rdat  = ref_mem.exists(g.addr) ? ref_mem[g.addr] : dflt(g.addr);
        end
      end else begin
        g.wdata = p1.wdata;
      end
      p1 = g;
      if (ec || !cpu_req) streak = 0;
      else if (ev) streak++;
    end
    va = ev;
    ca = ec;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit va, ca;
    vid_req = 1'b0;
    cpu_req = 1'b0;
    for (int i = 0; i < n; i++) step(va, ca);
  endtask

  initial begin
    bit va, ca;
    int base;
    resetn = 1'b0; vid_req = 1'b0; vid_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    p1 = '0; p2 = '0; streak = 0; exp_vrd = '0; exp_crd = '0; rst_prev = 1'b1;

    // Reset held with requests asserted: no acks, everything zero.
    vid_req = 1'b1; cpu_req = 1'b1;
    step(va, ca);
    step(va, ca);
    resetn = 1'b1;
    idle(2);

    // Single video read at 0x0010.
    vid_req = 1'b1; vid_addr = 16'h0010;
    step(va, ca);
    idle(3);

    // Contention: video wins, CPU read of 0x0020 granted once video drops.
    vid_req = 1'b1; vid_addr = 16'h0011;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020;
    step(va, ca);
    check("contend_vid_first", {30'b0, va, ca}, 32'h2);
    vid_req = 1'b0;
    step(va, ca);
    check("contend_cpu_next", {30'b0, va, ca}, 32'h1);
    idle(3);

    // CPU write then read-back of the same word.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0005; cpu_wdata = 24'hABCDEF;
    step(va, ca);
    cpu_we = 1'b0;
    step(va, ca);
    idle(3);

    // Both requesters held high: CPU gets in only through the starvation guard.
    base = obs_cpu_acks;
    vid_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0;
    for (int i = 0; i < 45; i++) begin
      step(va, ca);
      if (va) vid_addr = 16'($urandom_range(0, 63));
      if (ca) cpu_addr = 16'($urandom_range(0, 63));
    end
    check("starve_cpu_acks", obs_cpu_acks - base, STARVE_ON ? 5 : 0);
    idle(3);

    // Alternating reads every cycle: one rvalid per request.
    base = obs_rvalids;
    cpu_we = 1'b0;
    for (int i = 0; i < 100; i++) begin
      vid_req  = (i % 2) == 0;
      cpu_req  = (i % 2) == 1;
      vid_addr = 16'($urandom_range(0, 63));
      cpu_addr = 16'($urandom_range(0, 63));
      step(va, ca);
    end
    idle(2);
    check("alt_rvalid_count", obs_rvalids - base, 100);

    // Reset in the cycle after a video grant discards the read.
    vid_req = 1'b1; vid_addr = 16'h0033;
    step(va, ca);
    vid_req = 1'b0; resetn = 1'b0;
    step(va, ca);
    resetn = 1'b1;
    idle(3);

    // Random protocol-compliant traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if (!vid_req || va) begin
        vid_req  = ($urandom % 3) != 0;
        vid_addr = 16'($urandom_range(0, 63));
      end
      if (!cpu_req || ca) begin
        cpu_req   = ($urandom % 2) != 0;
        cpu_we    = ($urandom % 2) != 0;
        cpu_addr  = 16'($urandom_range(0, 63));
        cpu_wdata = 24'($urandom);
      end
      resetn = ($urandom % 60) != 0;
      step(va, ca);
    end
    resetn = 1'b1;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
